// File: rtl/cursor_pkg.sv
// Shared cursor-overlay types and default geometry widths.
package cursor_pkg;

  typedef enum logic [1:0] {
    OFF         = 2'b00,
    CROSS       = 2'b01,
    CROSS_BLINK = 2'b10,
    BOX         = 2'b11
  } cursor_mode_e;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_SIZE_W  = 5;

endpackage

// File: rtl/cursor_hit.sv
// Combinational coverage test of one pixel against one cursor's shadowed geometry.
module cursor_hit
  import cursor_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int SIZE_W  = DEF_SIZE_W
) (
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  cursor_mode_e       mode_i,
  input  logic               blink_phase_i,
  output logic               covered_o
);

  localparam int DW = COORD_W + 1;

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic        [DW-1:0] adx;
  logic        [DW-1:0] ady;
  logic        [DW-1:0] amax;
  logic        [DW-1:0] size_ext;
  logic                 cross_hit;
  logic                 box_hit;

  // One extra bit keeps off-screen offsets negative instead of wrapping.
  always_comb begin
    dx        = $signed({1'b0, draw_x_i}) - $signed({1'b0, cur_x_i});
    dy        = $signed({1'b0, draw_y_i}) - $signed({1'b0, cur_y_i});
    adx       = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ady       = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    amax      = (adx > ady) ? adx : ady;
    size_ext  = DW'(size_i);
    cross_hit = ((dx == '0) && (ady <= size_ext)) ||
                ((dy == '0) && (adx <= size_ext));
    box_hit   = (amax == size_ext);
    case (mode_i)
      CROSS:       covered_o = cross_hit;
      CROSS_BLINK: covered_o = cross_hit && blink_phase_i;
      BOX:         covered_o = box_hit;
      default:     covered_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cursor_overlay.sv
// Multi-cursor overlay: frame-synchronous cursor shadows, blink timer and a
// two-stage hit / priority pipeline producing hit, hit_id and blank per pixel.
module cursor_overlay
  import cursor_pkg::*;
#(
  parameter int  NUM_CURSORS  = 2,
  parameter int  COORD_W      = DEF_COORD_W,
  parameter int  SIZE_W       = DEF_SIZE_W,
  parameter int  BLINK_FRAMES = 30,
  localparam int ID_W         = (NUM_CURSORS > 1) ? $clog2(NUM_CURSORS) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           vsync,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_CURSORS*COORD_W-1:0] cur_x,
  input  logic [NUM_CURSORS*COORD_W-1:0] cur_y,
  input  logic [NUM_CURSORS*SIZE_W-1:0]  cur_size,
  input  logic [NUM_CURSORS*2-1:0]       cur_mode,
  output logic                           out_valid,
  output logic                           hit,
  output logic [ID_W-1:0]                hit_id,
  output logic                           blank
);

  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic                           vsync_q;
  logic                           vs_rise;
  logic [NUM_CURSORS*COORD_W-1:0] x_q;
  logic [NUM_CURSORS*COORD_W-1:0] y_q;
  logic [NUM_CURSORS*SIZE_W-1:0]  size_q;
  logic [NUM_CURSORS*2-1:0]       mode_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;
  logic                           blink_q;
  logic                           blink_d;
  logic [NUM_CURSORS-1:0]         covered;
  logic [NUM_CURSORS-1:0]         hitvec_p1_q;
  logic                           vld_p1_q;
  logic                           any_d;
  logic [ID_W-1:0]                id_d;
  logic                           out_valid_q;
  logic                           hit_q;
  logic [ID_W-1:0]                hit_id_q;
  logic                           blank_q;

  assign vs_rise = vsync & ~vsync_q;

  // Shadows change only on a frame edge; a pixel in that same cycle still
  // sees the old values because stage 1 samples the pre-update hit vector.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vsync_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      if (vs_rise) begin
        x_q    <= cur_x;
        y_q    <= cur_y;
        size_q <= cur_size;
        mode_q <= cur_mode;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (vs_rise) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CURSORS; g++) begin : g_hit
    cursor_hit #(
      .COORD_W (COORD_W),
      .SIZE_W  (SIZE_W)
    ) u_hit (
      .draw_x_i      (DrawX),
      .draw_y_i      (DrawY),
      .cur_x_i       (x_q[g*COORD_W +: COORD_W]),
      .cur_y_i       (y_q[g*COORD_W +: COORD_W]),
      .size_i        (size_q[g*SIZE_W +: SIZE_W]),
      .mode_i        (cursor_mode_e'(mode_q[g*2 +: 2])),
      .blink_phase_i (blink_q),
      .covered_o     (covered[g])
    );
  end

  // Stage 1: per-cursor hit vector.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1_q    <= 1'b0;
      hitvec_p1_q <= '0;
    end else begin
      vld_p1_q    <= pix_valid;
      hitvec_p1_q <= pix_valid ? covered : '0;
    end
  end

  always_comb begin
    any_d = |hitvec_p1_q;
    id_d  = '0;
    for (int i = NUM_CURSORS - 1; i >= 0; i--) begin
      if (hitvec_p1_q[i]) id_d = ID_W'(i);
    end
  end

  // Stage 2: priority-encoded result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_id_q    <= '0;
      blank_q     <= 1'b1;
    end else begin
      out_valid_q <= vld_p1_q;
      hit_q       <= vld_p1_q & any_d;
      hit_id_q    <= vld_p1_q ? id_d : '0;
      blank_q     <= ~(vld_p1_q & any_d);
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign hit_id    = hit_id_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Scoreboard bench for cursor_overlay: directed pixels push expectations, a monitor checks outputs.
module tb_cursor_overlay;

  localparam int NC = 2;
  localparam int CW = 10;
  localparam int SW = 5;
  localparam int BF = 2;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             vsync;
  logic             pix_valid;
  logic [CW-1:0]    DrawX;
  logic [CW-1:0]    DrawY;
  logic [NC*CW-1:0] cur_x;
  logic [NC*CW-1:0] cur_y;
  logic [NC*SW-1:0] cur_size;
  logic [NC*2-1:0]  cur_mode;
  logic             out_valid;
  logic             hit;
  logic [0:0]       hit_id;
  logic             blank;

  typedef struct {
    logic       h;
    logic [0:0] id;
    int         cyc;
    int         px;
    int         py;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   drain_cnt = 0;
  bit   stim_done = 1'b0;

  cursor_overlay #(
    .NUM_CURSORS  (NC),
    .COORD_W      (CW),
    .SIZE_W       (SW),
    .BLINK_FRAMES (BF)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .vsync     (vsync),
    .pix_valid (pix_valid),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .cur_size  (cur_size),
    .cur_mode  (cur_mode),
    .out_valid (out_valid),
    .hit       (hit),
    .hit_id    (hit_id),
    .blank     (blank)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: sole owner of the counters and the summary line.
  always @(negedge Clk) begin
    exp_t e;
    if (out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: out_valid=1 hit=%0b id=%0d at cycle %0d, required no output", hit, hit_id, cyc);
      end else begin
        e = sb.pop_front();
        if (hit !== e.h || hit_id !== e.id || blank !== ~e.h || (cyc - e.cyc) != 2) begin
          n_err++;
          $display("FAIL pixel(%0d,%0d): got hit=%0b id=%0d blank=%0b latency=%0d, required hit=%0b id=%0d blank=%0b latency=2",
                   e.px, e.py, hit, hit_id, blank, cyc - e.cyc, e.h, e.id, ~e.h);
        end
      end
    end else begin
      n_cmp++;
      if (blank !== 1'b1 || hit !== 1'b0 || hit_id !== 1'b0) begin
        n_err++;
        $display("FAIL idle_outputs: got blank=%0b hit=%0b id=%0d at cycle %0d, required blank=1 hit=0 id=0",
                 blank, hit, hit_id, cyc);
      end
    end
    if (stim_done) begin
      if (sb.size() == 0) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end else begin
        drain_cnt++;
        if (drain_cnt > 20) begin
          n_cmp++;
          n_err++;
          $display("FAIL drain_timeout: %0d pixels outstanding, required 0", sb.size());
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
          $finish;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_cur(input int i, input int x, input int y, input int s, input int m);
    cur_x[i*CW +: CW]    = CW'(x);
    cur_y[i*CW +: CW]    = CW'(y);
    cur_size[i*SW +: SW] = SW'(s);
    cur_mode[i*2 +: 2]   = 2'(m);
  endtask

  task automatic pix_drive(input int x, input int y, input bit h, input int id, input bit vs);
    exp_t e;
    @(posedge Clk);
    #1;
    vsync     = vs;
    pix_valid = 1'b1;
    DrawX     = CW'(x);
    DrawY     = CW'(y);
    e.h   = h;
    e.id  = 1'(id);
    e.cyc = cyc;
    e.px  = x;
    e.py  = y;
    sb.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input bit h, input int id);
    pix_drive(x, y, h, id, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      pix_valid = 1'b0;
      vsync     = 1'b0;
    end
  endtask

  task automatic frame();
    @(posedge Clk);
    #1;
    pix_valid = 1'b0;
    vsync     = 1'b1;
    @(posedge Clk);
    #1;
    vsync = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    vsync     = 1'b0;
    pix_valid = 1'b0;
    DrawX     = '0;
    DrawY     = '0;
    cur_x     = '0;
    cur_y     = '0;
    cur_size  = '0;
    cur_mode  = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(2);

    // Solid crosshair, row scan through the centre plus vertical arm.
    set_cur(0, 320, 240, 4, 1);
    set_cur(1, 0, 0, 0, 0);
    frame();
    for (int x = 312; x <= 328; x++) pix(x, 240, (x >= 316 && x <= 324), 0);
    pix(320, 236, 1, 0);
    pix(320, 235, 0, 0);
    pix(320, 244, 1, 0);
    pix(321, 241, 0, 0);
    idle(3);

    // Box outline.
    set_cur(0, 100, 100, 2, 3);
    frame();
    pix(98, 98, 1, 0);
    pix(102, 101, 1, 0);
    pix(100, 100, 0, 0);
    pix(103, 100, 0, 0);
    pix(100, 102, 1, 0);
    pix(99, 99, 0, 0);
    idle(3);

    // Overlap priority.
    set_cur(0, 5, 5, 3, 1);
    set_cur(1, 5, 7, 3, 1);
    frame();
    pix(5, 6, 1, 0);
    pix(5, 10, 1, 1);
    pix(8, 7, 1, 1);
    set_cur(0, 5, 5, 3, 0);
    frame();
    pix(5, 6, 1, 1);
    idle(3);

    // Cursor at the screen corner: no wrap to coordinate 1023.
    set_cur(0, 0, 0, 5, 1);
    set_cur(1, 0, 0, 0, 0);
    frame();
    pix(0, 0, 1, 0);
    pix(5, 0, 1, 0);
    pix(6, 0, 0, 0);
    pix(1023, 0, 0, 0);
    pix(0, 1023, 0, 0);
    pix(0, 3, 1, 0);
    idle(3);

    // Mid-frame input change and vsync coincident with a pixel.
    set_cur(0, 200, 200, 1, 1);
    frame();
    set_cur(0, 300, 300, 1, 1);
    pix(200, 200, 1, 0);
    pix(300, 300, 0, 0);
    pix_drive(200, 201, 1, 0, 1'b1);
    pix(200, 201, 0, 0);
    pix(300, 299, 1, 0);
    idle(3);

    // Asynchronous reset with two pixels in flight.
    pix(300, 300, 1, 0);
    pix(300, 301, 1, 0);
    @(posedge Clk);
    #2;
    Reset     = 1'b1;
    pix_valid = 1'b0;
    sb.delete();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(3);
    pix(300, 300, 0, 0);
    idle(3);

    // Blink with BLINK_FRAMES=2; frame count restarts at reset.
    set_cur(0, 10, 10, 0, 1);
    set_cur(1, 50, 60, 0, 2);
    frame();
    pix(50, 60, 1, 1);
    pix(10, 10, 1, 0);
    frame();
    pix(50, 60, 0, 0);
    pix(10, 10, 1, 0);
    frame();
    pix(50, 60, 0, 0);
    frame();
    pix(50, 60, 1, 1);
    idle(3);

    stim_done = 1'b1;
  end

endmodule
